// File: rtl/md5_block_padder_pkg.sv
// Shared MD5 definitions used by the block padder and the downstream hasher core:
// block geometry, padding constants, the padder FSM state type and the length-field helper.
package md5_pkg;

    localparam int unsigned MD5_BLOCK_BITS = 512;
    localparam logic [7:0]  MD5_PAD_BYTE   = 8'h80;
    localparam int          MD5_LEN_OFFSET = 56;

    typedef logic [MD5_BLOCK_BITS-1:0] md5_block_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        PAD     = 2'd2,
        HOLD    = 2'd3
    } pad_state_e;

    // Message length in bits as the 64-bit little-endian trailer of a single block.
    function automatic logic [63:0] md5_len_field(input logic [5:0] len_bytes);
        return {55'd0, len_bytes, 3'b000};
    endfunction

endpackage

// File: rtl/md5_block_padder_if.sv
// Byte-stream input and padded-block output of the MD5 block padder.
// slave = padder side, master = feeder/hasher side.
interface md5_block_padder_if;
    import md5_pkg::*;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    md5_block_t m_block;
    logic [5:0] m_len;
    logic       m_valid;
    logic       m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_block, m_len, m_valid
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_block, m_len, m_valid
    );

endinterface

// File: rtl/md5_block_padder.sv
// Collects one byte-stream message and emits a single MD5-padded 512-bit block.
// Optional MD5_PAD_STATS_EN adds msg_cnt/ovf_cnt handoff and drop counters.
module md5_block_padder
    import md5_pkg::*;
#(
    parameter int unsigned MAX_LEN = 55
) (
    input  logic                 clock,
    input  logic                 reset,
    md5_block_padder_if.slave    io,
    output logic                 ovf_pulse
`ifdef MD5_PAD_STATS_EN
    ,
    output logic [31:0]          msg_cnt,
    output logic [15:0]          ovf_cnt
`endif
);

    pad_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    md5_block_t buf_q, buf_d;
    logic       s_ready_q, s_ready_d;
    logic       m_valid_q, m_valid_d;
    logic [5:0] m_len_q, m_len_d;
    logic       ovf_pulse_q, ovf_pulse_d;

    logic        accept;
    logic        handoff;
    logic        wr_en;
    logic [5:0]  wr_lane;
    logic [7:0]  wr_byte;
    logic        len_wr;
    logic        clr;
    logic [63:0] len_field;

    assign accept    = io.s_valid & s_ready_q;
    assign handoff   = m_valid_q & io.m_ready;
    assign wr_lane   = cnt_q;
    assign len_field = md5_len_field(cnt_q);

    // Next-state, lane-write and handshake control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = 1'b0;
        m_len_d     = m_len_q;
        ovf_pulse_d = 1'b0;
        wr_en       = 1'b0;
        wr_byte     = io.s_data;
        len_wr      = 1'b0;
        clr         = 1'b0;
        case (state_q)
            COLLECT: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    if (cnt_q == 6'(MAX_LEN)) begin
                        if (io.s_last) begin
                            clr         = 1'b1;
                            cnt_d       = 6'd0;
                            ovf_pulse_d = 1'b1;
                            state_d     = COLLECT;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 6'd1;
                        if (io.s_last) begin
                            state_d   = PAD;
                            s_ready_d = 1'b0;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            DISCARD: begin
                s_ready_d = 1'b1;
                if (accept && io.s_last) begin
                    clr         = 1'b1;
                    cnt_d       = 6'd0;
                    ovf_pulse_d = 1'b1;
                    state_d     = COLLECT;
                end else begin
                    state_d = DISCARD;
                end
            end
            PAD: begin
                // cnt already equals the message length, so it indexes the marker lane.
                s_ready_d = 1'b0;
                wr_en     = 1'b1;
                wr_byte   = MD5_PAD_BYTE;
                len_wr    = 1'b1;
                m_len_d   = cnt_q;
                state_d   = HOLD;
            end
            HOLD: begin
                if (handoff) begin
                    clr       = 1'b1;
                    cnt_d     = 6'd0;
                    s_ready_d = 1'b1;
                    state_d   = COLLECT;
                end else begin
                    s_ready_d = 1'b0;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            default: begin
                clr       = 1'b1;
                cnt_d     = 6'd0;
                s_ready_d = 1'b0;
                state_d   = COLLECT;
            end
        endcase
    end

    for (genvar i = 0; i < 64; i++) begin : g_lane
        if (i >= MD5_LEN_OFFSET) begin : g_len_lane
            assign buf_d[8*i +: 8] = clr                          ? 8'h00 :
                                     (wr_en && wr_lane == 6'(i))  ? wr_byte :
                                     len_wr                       ? len_field[8*(i-MD5_LEN_OFFSET) +: 8] :
                                                                    buf_q[8*i +: 8];
        end else begin : g_msg_lane
            assign buf_d[8*i +: 8] = clr                          ? 8'h00 :
                                     (wr_en && wr_lane == 6'(i))  ? wr_byte :
                                                                    buf_q[8*i +: 8];
        end
    end

    // FSM state, buffer and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= COLLECT;
            cnt_q       <= 6'd0;
            buf_q       <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_len_q     <= 6'd0;
            ovf_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_len_q     <= m_len_d;
            ovf_pulse_q <= ovf_pulse_d;
        end
    end

    assign io.s_ready = s_ready_q;
    assign io.m_block = buf_q;
    assign io.m_len   = m_len_q;
    assign io.m_valid = m_valid_q;
    assign ovf_pulse  = ovf_pulse_q;

`ifdef MD5_PAD_STATS_EN
    logic [31:0] msg_cnt_q, msg_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Wrapping handoff / drop counters.
    always_comb begin
        msg_cnt_d = handoff     ? msg_cnt_q + 32'd1 : msg_cnt_q;
        ovf_cnt_d = ovf_pulse_q ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            msg_cnt_q <= 32'd0;
            ovf_cnt_q <= 16'd0;
        end else begin
            msg_cnt_q <= msg_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign msg_cnt = msg_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_md5_block_padder.sv
// Directed self-checking bench for md5_block_padder (counter checks when MD5_PAD_STATS_EN is defined).
module tb_md5_block_padder;
    import md5_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ovf_pulse;
`ifdef MD5_PAD_STATS_EN
    logic [31:0] msg_cnt;
    logic [15:0] ovf_cnt;
`endif

    int tests = 0;
    int fails = 0;

    md5_block_padder_if io();

    md5_block_padder #(.MAX_LEN(55)) dut (
        .clock     (clock),
        .reset     (reset),
        .io        (io),
        .ovf_pulse (ovf_pulse)
`ifdef MD5_PAD_STATS_EN
        ,
        .msg_cnt   (msg_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard;
        guard = 0;
        io.s_data  = d;
        io.s_last  = last;
        io.s_valid = 1'b1;
        while (io.s_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk("s_ready_wait", {511'd0, guard < 50}, 512'd1);
        tick();
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        foreach (msg[i]) send_byte(msg[i], (i == msg.size() - 1));
    endtask

    // Called right after the last byte's accepting edge: checks 2-edge latency, contents, handoff.
    task automatic get_block(input string tag, input md5_block_t exp_blk, input logic [5:0] exp_len);
        chk({tag, "_mvalid_n0"}, io.m_valid, 1'b0);
        tick();
        chk({tag, "_mvalid_n1"}, io.m_valid, 1'b0);
        tick();
        chk({tag, "_mvalid_n2"}, io.m_valid, 1'b1);
        chk({tag, "_block"}, io.m_block, exp_blk);
        chk({tag, "_len"}, io.m_len, exp_len);
        io.m_ready = 1'b1;
        tick();
        io.m_ready = 1'b0;
        chk({tag, "_mvalid_after"}, io.m_valid, 1'b0);
        chk({tag, "_sready_after"}, io.s_ready, 1'b1);
    endtask

    // Sends an oversize message and checks the one-cycle drop pulse and absence of m_valid.
    task automatic send_oversize(input string tag, input int n);
        for (int i = 0; i < n; i++) send_byte(8'h55, (i == n - 1));
        chk({tag, "_ovf_hi"}, ovf_pulse, 1'b1);
        chk({tag, "_mvalid0"}, io.m_valid, 1'b0);
        tick();
        chk({tag, "_ovf_lo"}, ovf_pulse, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_no_mvalid"}, io.m_valid, 1'b0);
        end
    endtask

    initial begin
        md5_block_t exp_blk;
        md5_block_t held_blk;
        logic [7:0] msg[$];

        io.s_data  = 8'h00;
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
        io.m_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_sready", io.s_ready, 1'b0);
        chk("rst_mvalid", io.m_valid, 1'b0);
        chk("rst_mblock", io.m_block, 512'd0);
        chk("rst_mlen", io.m_len, 6'd0);
        chk("rst_ovf", ovf_pulse, 1'b0);
        reset = 1'b0;
        tick();
        chk("rst_sready_after", io.s_ready, 1'b1);

        // 1: "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg);
        exp_blk = '0;
        exp_blk[31:0]    = 32'h80636261;
        exp_blk[479:448] = 32'h00000018;
        get_block("abc", exp_blk, 6'd3);

        // 2: 55 bytes of 0x41 (largest legal message)
        for (int i = 0; i < 55; i++) send_byte(8'h41, (i == 54));
        exp_blk = '0;
        for (int i = 0; i < 55; i++) exp_blk[8*i +: 8] = 8'h41;
        exp_blk[447:440] = 8'h80;
        exp_blk[479:448] = 32'h000001B8;
        get_block("max55", exp_blk, 6'd55);

        // 3: 56-byte message dropped, then "a" is clean
        send_oversize("ovf56", 56);
        msg = '{8'h61};
        send_msg(msg);
        exp_blk = '0;
        exp_blk[31:0]    = 32'h00008061;
        exp_blk[479:448] = 32'h00000008;
        get_block("after_ovf", exp_blk, 6'd1);

        // 4: back-pressure in HOLD
        msg = '{8'h78, 8'h79};
        send_msg(msg);
        tick();
        tick();
        chk("hold_mvalid", io.m_valid, 1'b1);
        held_blk = '0;
        held_blk[31:0]    = 32'h00807978;
        held_blk[479:448] = 32'h00000010;
        chk("hold_block", io.m_block, held_blk);
        io.s_data  = 8'h7a;
        io.s_last  = 1'b1;
        io.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_stable", io.m_block, held_blk);
            chk("hold_sready", io.s_ready, 1'b0);
            chk("hold_mvalid_kept", io.m_valid, 1'b1);
        end
        io.m_ready = 1'b1;
        tick();
        io.m_ready = 1'b0;
        chk("hold_release_mvalid", io.m_valid, 1'b0);
        chk("hold_release_sready", io.s_ready, 1'b1);
        chk("hold_release_cleared", io.m_block, 512'd0);
        send_byte(8'h7a, 1'b1);
        exp_blk = '0;
        exp_blk[31:0]    = 32'h0000807a;
        exp_blk[479:448] = 32'h00000008;
        get_block("post_hold", exp_blk, 6'd1);

        // 5: reset after 20 bytes
        for (int i = 0; i < 20; i++) send_byte(8'h33, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        chk("midrst_sready", io.s_ready, 1'b0);
        chk("midrst_mvalid", io.m_valid, 1'b0);
        chk("midrst_mblock", io.m_block, 512'd0);
        chk("midrst_mlen", io.m_len, 6'd0);
        chk("midrst_ovf", ovf_pulse, 1'b0);
        reset = 1'b0;
        tick();
        chk("midrst_sready_after", io.s_ready, 1'b1);
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg);
        exp_blk = '0;
        exp_blk[31:0]    = 32'h80636261;
        exp_blk[479:448] = 32'h00000018;
        get_block("abc_again", exp_blk, 6'd3);

        // 6: two more good messages, two oversize (direct drop and DISCARD path)
        msg = '{8'h5a};
        send_msg(msg);
        exp_blk = '0;
        exp_blk[31:0]    = 32'h0000805a;
        exp_blk[479:448] = 32'h00000008;
        get_block("z_upper", exp_blk, 6'd1);
        send_oversize("ovf60", 60);
        msg = '{8'h61, 8'h62, 8'h63, 8'h64};
        send_msg(msg);
        exp_blk = '0;
        exp_blk[31:0]    = 32'h64636261;
        exp_blk[63:32]   = 32'h00000080;
        exp_blk[479:448] = 32'h00000020;
        get_block("abcd", exp_blk, 6'd4);
        send_oversize("ovf56b", 56);
`ifdef MD5_PAD_STATS_EN
        chk("stats_msg_cnt", msg_cnt, 32'd3);
        chk("stats_ovf_cnt", ovf_cnt, 16'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
